// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access path: request size encodings,
// controller FSM states and the default memory depth.
package mem_access_pkg;

    localparam int MEM_WORDS_DEFAULT = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling for 32-bit little-endian words: extracts and
// extends a load lane, and merges store data into a read-back word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_t       size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Each byte lane either keeps the read-back byte or takes the matching store byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;

            assign hit = (size == SZ_WORD)
                      || (size == SZ_BYTE && lane == LANE)
                      || (size == SZ_HALF && lane[1] == LANE[1]);
            assign src = (size == SZ_BYTE) ? wdata[7:0]
                       : (size == SZ_HALF) ? wdata[8*(gi%2) +: 8]
                       : wdata[8*gi +: 8];
            assign merged_word[8*gi +: 8] = hit ? src : word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Core-side load/store controller for a word-addressed data memory; sub-word
// stores are read-modify-write, every transaction ends with a one-cycle response.
module data_mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t            state_reg, state_next;
    logic              write_reg;
    size_t             size_reg;
    logic              signed_reg;
    logic [1:0]        lane_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              accept, req_error;
    logic [31:0]       load_data, merged_word;
    logic              resp_valid_next, resp_error_next, mem_write_next;
    logic [DATA_W-1:0] resp_rdata_next, mem_write_data_next;
    logic [31:0]       mem_address_next;

    assign req_ready = (state_reg == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    assign req_error = (req_size == SZ_BAD)
                    || (req_size == SZ_HALF && req_addr[0])
                    || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                    || (req_addr[31:2] >= WORD_LIMIT);

    mem_lane_align u_align (
        .word        (mem_read_data),
        .lane        (lane_reg),
        .size        (size_reg),
        .is_signed   (signed_reg),
        .wdata       (wdata_reg),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            write_reg      <= 1'b0;
            size_reg       <= SZ_BYTE;
            signed_reg     <= 1'b0;
            lane_reg       <= 2'b00;
            wdata_reg      <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_write      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mem_address    <= mem_address_next;
            mem_write_data <= mem_write_data_next;
            mem_write      <= mem_write_next;
            resp_valid     <= resp_valid_next;
            resp_rdata     <= resp_rdata_next;
            resp_error     <= resp_error_next;
            if (accept) begin
                write_reg  <= req_write;
                size_reg   <= size_t'(req_size);
                signed_reg <= req_signed;
                lane_reg   <= req_addr[1:0];
                wdata_reg  <= req_wdata;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_error)                            state_next = ST_RESP;
                    else if (req_write && req_size == SZ_WORD) state_next = ST_WR;
                    else                                      state_next = ST_RD;
                end
            end
            ST_RD:   state_next = write_reg ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are computed one state ahead so they leave the block registered.
    always_comb begin
        mem_address_next    = mem_address;
        mem_write_data_next = mem_write_data;
        mem_write_next      = 1'b0;
        resp_valid_next     = 1'b0;
        resp_rdata_next     = '0;
        resp_error_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    mem_address_next = {2'b00, req_addr[31:2]};
                    if (req_error) begin
                        resp_valid_next = 1'b1;
                        resp_error_next = 1'b1;
                    end else if (req_write && req_size == SZ_WORD) begin
                        mem_write_next      = 1'b1;
                        mem_write_data_next = req_wdata;
                    end
                end
            end
            ST_RD: begin
                if (write_reg) begin
                    mem_write_next      = 1'b1;
                    mem_write_data_next = merged_word;
                end else begin
                    resp_valid_next = 1'b1;
                    resp_rdata_next = load_data;
                end
            end
            ST_WR:   resp_valid_next = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/data_mem_access_ctrl.md
Name: data_mem_access_ctrl

Overview:
- Initiator side of the data-memory interface: accepts byte/half/word load and store requests from the core and drives the word-addressed data memory.
- Sub-word stores are done as read-modify-write.
- Sits between the execute/memory stage and the data memory.
- Returns load data, sign- or zero-extended, with a one-cycle response pulse.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in data memory; legal word index is 0..MEM_WORDS-1.
- DATA_W, 32, data width; fixed at 32, only the default is supported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE and gated with !reset.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address, little-endian.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  qualifies resp_valid: misaligned, illegal size or out of range.
- mem_address  out  32  word index, req_addr[31:2].
- mem_write_data  out  32  full word to write.
- mem_write  out  1  write strobe; memory commits on the falling edge of clk while high.
- mem_read_data  in  32  combinational read of mem_data[mem_address].

Behaviour:
- Reset (async): state=IDLE. mem_address, mem_write_data, mem_write, resp_valid, resp_rdata, resp_error all 0. Latched request cleared.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. Request fields are latched at acceptance, so inputs may change afterwards. Only one transaction is in flight.
- At acceptance, error check:
  - req_size==11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:2] >= MEM_WORDS.
  - If any fails, go to RESP with resp_error=1. No memory access; mem_write stays 0.
- FSM states are IDLE, RD, WR, RESP. All outputs are registered.
- IDLE: on accept, load mem_address.
  - Load, or sub-word store → RD.
  - Word store → WR, with mem_write_data=req_wdata.
  - Error → RESP.
- RD: mem_address stable for the full cycle; mem_read_data is sampled at the closing rising edge.
  - Load: extract lane (byte lane=addr[1:0], half lane=addr[1]), extend per req_signed, load resp_rdata → RESP.
  - Sub-word store: mem_write_data = read word with the addressed lane replaced by req_wdata[7:0] or [15:0] → WR.
- WR: mem_write=1 for exactly one cycle, with address and data held stable through the falling edge → RESP. mem_write returns to 0 on exit.
- RESP: resp_valid=1 for exactly one cycle, with resp_rdata/resp_error valid in that cycle → IDLE. Both resp_valid and resp_error clear on exit.
- Latency from accept edge to resp_valid cycle:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: the next request can be accepted in the cycle after RESP. req_ready is low during RD, WR and RESP.
- Reset mid-operation: the transaction is aborted and mem_write drops immediately. If reset is asserted in WR before the falling edge, the write is lost. No resp_valid is issued for an aborted transaction.
- Word stores never read memory. Loads never assert mem_write.

Decomposition:
- Shared package mem_access_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum;
  - MEM_WORDS default.
- One combinational sub-module mem_lane_align provides:
  - a lane-extract + sign/zero-extend path for loads;
  - a lane-merge path for stores.
- It is reused by the core's future cache path.

Test Plan:
- Reset, then load word at addr 0x14 (memory preloaded, word 5 = 0x5) → resp_valid exactly 2 cycles after accept, resp_rdata=0x00000005, resp_error=0. Hold req_valid high through the transaction → req_ready=0 in RD/RESP, the second request is accepted only after RESP.
- Store byte 0xAB at addr 0x29 (word 10 = 0x10) → sequence RD, WR. In WR, mem_write=1 for one cycle with mem_address=10 and mem_write_data=0x0000AB10. A following load word at 0x28 returns 0x0000AB10.
- Load byte at 0x29: signed → 0xFFFFFFAB, unsigned → 0x000000AB. Load half at 0x2A, signed, after storing half 0x8001 there → 0xFFFF8001.
- Half load at 0x03, size=11 at 0x00, and word load at 0x80 (index 32) → each gives resp_error=1 one cycle after accept, resp_rdata=0, mem_write never high, memory unchanged.
- Word store 0xDEADBEEF at 0x7C (index 31) → no RD state, mem_write pulse in the cycle after accept, resp_valid in the following cycle. A readback returns 0xDEADBEEF.
- Assert reset during WR before the falling edge → mem_write=0 immediately, no resp_valid, target word unchanged. req_ready=1 once reset releases.
